// File: rtl/pacman_mover.sv
// Pac-Man datapath: registered grid position, wall-derived move enables,
// pellet map with score/remaining counters, and sticky win/loose flags.
module pacman_mover #(
    parameter int GRID_W = 16,
    parameter int GRID_H = 16,
    parameter logic [GRID_W*GRID_H-1:0] MAZE = '0,
    parameter int START_X  = 1,
    parameter int START_Y  = 1,
    parameter int PELLETS  = 1,
    parameter int TICK_DIV = 1,
    parameter int XW = (GRID_W > 1) ? $clog2(GRID_W) : 1,
    parameter int YW = (GRID_H > 1) ? $clog2(GRID_H) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          m_up,
    input  logic          m_down,
    input  logic          m_right,
    input  logic          m_left,
    input  logic          m_hold,
    input  logic          e_start,
    input  logic [XW-1:0] ghost_x,
    input  logic [YW-1:0] ghost_y,
    input  logic          ghost_valid,
    output logic [XW-1:0] pac_x,
    output logic [YW-1:0] pac_y,
    output logic          uE,
    output logic          dE,
    output logic          rE,
    output logic          lE,
    output logic [7:0]    score,
    output logic          win,
    output logic          loose
);

    localparam int N  = GRID_W * GRID_H;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [N-1:0] START_BIT   = {{(N-1){1'b0}}, 1'b1} << (START_Y * GRID_W + START_X);
    localparam logic [N-1:0] PELLET_INIT = ~MAZE & ~START_BIT;
    localparam logic [XW-1:0] START_XV   = XW'(START_X);
    localparam logic [YW-1:0] START_YV   = YW'(START_Y);
    localparam logic [7:0]    PELLETS_V  = 8'(PELLETS);
    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);

    logic [XW-1:0] pos_x_q, pos_x_d;
    logic [YW-1:0] pos_y_q, pos_y_d;
    logic [N-1:0]  pellet_q, pellet_d;
    logic [7:0]    score_q, score_d;
    logic [7:0]    remaining_q, remaining_d;
    logic          win_q, win_d;
    logic          loose_q, loose_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;

    logic [CW-1:0] cell_i, up_i, dn_i, rt_i, lt_i;
    logic          tick, over, eat, hit, strobe_any;

    always_comb begin
        cell_i = CW'(int'(pos_y_q) * GRID_W + int'(pos_x_q));
        up_i   = cell_i - CW'(GRID_W);
        dn_i   = cell_i + CW'(GRID_W);
        rt_i   = cell_i + CW'(1);
        lt_i   = cell_i - CW'(1);
        // Grid edges are treated as walls; the neighbour index is only
        // consulted when the edge test passes.
        uE = (pos_y_q != '0) && !MAZE[up_i];
        dE = (pos_y_q != YW'(GRID_H - 1)) && !MAZE[dn_i];
        rE = (pos_x_q != XW'(GRID_W - 1)) && !MAZE[rt_i];
        lE = (pos_x_q != '0) && !MAZE[lt_i];
    end

    always_comb begin
        tick       = (tick_cnt_q == TICK_LAST);
        over       = win_q | loose_q;
        strobe_any = m_up | m_down | m_right | m_left | m_hold;
        eat        = pellet_q[cell_i] && !over;
        hit        = ghost_valid && (ghost_x == pos_x_q) && (ghost_y == pos_y_q) && !over;

        pos_x_d     = pos_x_q;
        pos_y_d     = pos_y_q;
        pellet_d    = pellet_q;
        score_d     = score_q;
        remaining_d = remaining_q;
        win_d       = win_q;
        loose_d     = loose_q;
        tick_cnt_d  = tick ? '0 : tick_cnt_q + TW'(1);

        if (e_start) begin
            pos_x_d     = START_XV;
            pos_y_d     = START_YV;
            pellet_d    = PELLET_INIT;
            score_d     = '0;
            remaining_d = PELLETS_V;
            win_d       = 1'b0;
            loose_d     = 1'b0;
            tick_cnt_d  = '0;
        end else begin
            if (tick && !over && strobe_any) begin
                if (m_up && uE)
                    pos_y_d = pos_y_q - YW'(1);
                else if (m_down && dE)
                    pos_y_d = pos_y_q + YW'(1);
                else if (m_right && rE)
                    pos_x_d = pos_x_q + XW'(1);
                else if (m_left && lE)
                    pos_x_d = pos_x_q - XW'(1);
            end
            if (eat) begin
                pellet_d[cell_i] = 1'b0;
                score_d          = score_q + 8'd1;
                remaining_d      = remaining_q - 8'd1;
                // A collision on the final pellet still scores it but loses.
                if (remaining_q == 8'd1 && !hit)
                    win_d = 1'b1;
            end
            if (hit)
                loose_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pos_x_q     <= START_XV;
            pos_y_q     <= START_YV;
            pellet_q    <= PELLET_INIT;
            score_q     <= '0;
            remaining_q <= PELLETS_V;
            win_q       <= 1'b0;
            loose_q     <= 1'b0;
            tick_cnt_q  <= '0;
        end else begin
            pos_x_q     <= pos_x_d;
            pos_y_q     <= pos_y_d;
            pellet_q    <= pellet_d;
            score_q     <= score_d;
            remaining_q <= remaining_d;
            win_q       <= win_d;
            loose_q     <= loose_d;
            tick_cnt_q  <= tick_cnt_d;
        end
    end

    assign pac_x = pos_x_q;
    assign pac_y = pos_y_q;
    assign score = score_q;
    assign win   = win_q;
    assign loose = loose_q;

endmodule

// File: tb/tb_pacman_mover.sv
// Bench for pacman_mover: directed scenarios plus randomized play, checked
// against a cell-level game model for TICK_DIV=1 (dut a) and TICK_DIV=4 (dut b).
module tb_pacman_mover;

    localparam logic [15:0] MAZE_P = 16'hF99F;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic m_up = 0, m_down = 0, m_right = 0, m_left = 0, m_hold = 0, e_start = 0;
    logic [1:0] ghost_x = 0, ghost_y = 0;
    logic ghost_valid = 0;

    logic [1:0] a_pac_x, a_pac_y, b_pac_x, b_pac_y;
    logic a_uE, a_dE, a_rE, a_lE, b_uE, b_dE, b_rE, b_lE;
    logic [7:0] a_score, b_score;
    logic a_win, a_loose, b_win, b_loose;
    logic [17:0] a_vec, b_vec;

    int errors = 0;
    int checks = 0;

    int mx[2], my[2], msc[2], mrem[2], mwin[2], mlos[2], mtc[2];
    int pel[2][4][4];

    always #5 clk = ~clk;

    pacman_mover #(.GRID_W(4), .GRID_H(4), .MAZE(MAZE_P), .START_X(1), .START_Y(1),
                   .PELLETS(3), .TICK_DIV(1)) dut_a (
        .clk(clk), .reset(reset), .m_up(m_up), .m_down(m_down), .m_right(m_right),
        .m_left(m_left), .m_hold(m_hold), .e_start(e_start), .ghost_x(ghost_x),
        .ghost_y(ghost_y), .ghost_valid(ghost_valid), .pac_x(a_pac_x), .pac_y(a_pac_y),
        .uE(a_uE), .dE(a_dE), .rE(a_rE), .lE(a_lE), .score(a_score), .win(a_win),
        .loose(a_loose));

    pacman_mover #(.GRID_W(4), .GRID_H(4), .MAZE(MAZE_P), .START_X(1), .START_Y(1),
                   .PELLETS(3), .TICK_DIV(4)) dut_b (
        .clk(clk), .reset(reset), .m_up(m_up), .m_down(m_down), .m_right(m_right),
        .m_left(m_left), .m_hold(m_hold), .e_start(e_start), .ghost_x(ghost_x),
        .ghost_y(ghost_y), .ghost_valid(ghost_valid), .pac_x(b_pac_x), .pac_y(b_pac_y),
        .uE(b_uE), .dE(b_dE), .rE(b_rE), .lE(b_lE), .score(b_score), .win(b_win),
        .loose(b_loose));

    assign a_vec = {a_pac_x, a_pac_y, a_uE, a_dE, a_rE, a_lE, a_score, a_win, a_loose};
    assign b_vec = {b_pac_x, b_pac_y, b_uE, b_dE, b_rE, b_lE, b_score, b_win, b_loose};

    function automatic bit open_cell(int x, int y);
        logic [15:0] mz;
        mz = MAZE_P;
        if (x < 0 || x > 3 || y < 0 || y > 3) return 1'b0;
        return !mz[y*4 + x];
    endfunction

    function automatic int td(int m);
        return (m == 0) ? 1 : 4;
    endfunction

    task automatic model_reset(int m);
        mx[m] = 1; my[m] = 1; msc[m] = 0; mrem[m] = 3;
        mwin[m] = 0; mlos[m] = 0; mtc[m] = 0;
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 4; x++)
                pel[m][y][x] = (open_cell(x, y) && !(x == 1 && y == 1)) ? 1 : 0;
    endtask

    // One clock edge of the game rules, using the inputs present at the edge.
    task automatic model_step(int m);
        bit tick, over, hit, eat;
        int nx, ny;
        if (e_start) begin
            model_reset(m);
            return;
        end
        tick = (mtc[m] == td(m) - 1);
        mtc[m] = (mtc[m] + 1) % td(m);
        over = (mwin[m] != 0) || (mlos[m] != 0);
        hit  = ghost_valid && (int'(ghost_x) == mx[m]) && (int'(ghost_y) == my[m]) && !over;
        eat  = (pel[m][my[m]][mx[m]] != 0) && !over;
        nx = mx[m];
        ny = my[m];
        if (tick && !over) begin
            if (m_up && open_cell(mx[m], my[m] - 1)) ny = my[m] - 1;
            else if (m_down && open_cell(mx[m], my[m] + 1)) ny = my[m] + 1;
            else if (m_right && open_cell(mx[m] + 1, my[m])) nx = mx[m] + 1;
            else if (m_left && open_cell(mx[m] - 1, my[m])) nx = mx[m] - 1;
        end
        if (eat) begin
            pel[m][my[m]][mx[m]] = 0;
            msc[m]++;
            mrem[m]--;
            if (mrem[m] == 0 && !hit) mwin[m] = 1;
        end
        if (hit) mlos[m] = 1;
        mx[m] = nx;
        my[m] = ny;
    endtask

    function automatic logic [17:0] exp_vec(int m);
        return {2'(mx[m]), 2'(my[m]),
                open_cell(mx[m], my[m] - 1), open_cell(mx[m], my[m] + 1),
                open_cell(mx[m] + 1, my[m]), open_cell(mx[m] - 1, my[m]),
                8'(msc[m]), 1'(mwin[m]), 1'(mlos[m])};
    endfunction

    task automatic step();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        model_reset(0);
        model_reset(1);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic clear_inputs();
        m_up = 0; m_down = 0; m_right = 0; m_left = 0; m_hold = 0; e_start = 0;
        ghost_valid = 0; ghost_x = 0; ghost_y = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        apply_reset();
        checks++;
        if (a_vec !== {2'd1, 2'd1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_a actual=%h required=%h", a_vec, {2'd1, 2'd1, 4'b0110, 10'd0});
        end
        checks++;
        if (b_vec !== {2'd1, 2'd1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_b actual=%h required=%h", b_vec, {2'd1, 2'd1, 4'b0110, 10'd0});
        end
    endtask

    task automatic test_right_wall();
        clear_inputs();
        apply_reset();
        m_right = 1; step(); m_right = 0;
        checks++;
        if ({a_pac_x, a_pac_y, a_rE, a_score} !== {2'd2, 2'd1, 1'b0, 8'd0}) begin
            errors++;
            $display("FAIL right_move actual x=%0d y=%0d rE=%b score=%0d required x=2 y=1 rE=0 score=0",
                     a_pac_x, a_pac_y, a_rE, a_score);
        end
        step();
        checks++;
        if (a_score !== 8'd1) begin
            errors++;
            $display("FAIL right_eat actual=%0d required=1", a_score);
        end
        m_right = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({a_pac_x, a_pac_y, a_score} !== {2'd2, 2'd1, 8'd1}) begin
                errors++;
                $display("FAIL right_wall actual x=%0d y=%0d score=%0d required x=2 y=1 score=1",
                         a_pac_x, a_pac_y, a_score);
            end
        end
        m_right = 0;
    endtask

    task automatic run_to_win();
        m_right = 1; step(); m_right = 0;
        m_down = 1; step(); m_down = 0;
        m_left = 1; step(); m_left = 0;
    endtask

    task automatic test_win();
        clear_inputs();
        apply_reset();
        run_to_win();
        checks++;
        if ({a_pac_x, a_pac_y, a_score, a_win} !== {2'd1, 2'd2, 8'd2, 1'b0}) begin
            errors++;
            $display("FAIL win_path actual x=%0d y=%0d score=%0d win=%b required x=1 y=2 score=2 win=0",
                     a_pac_x, a_pac_y, a_score, a_win);
        end
        step();
        checks++;
        if ({a_pac_x, a_pac_y, a_score, a_win, a_loose} !== {2'd1, 2'd2, 8'd3, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL win_set actual score=%0d win=%b loose=%b required score=3 win=1 loose=0",
                     a_score, a_win, a_loose);
        end
        m_up = 1; step(); m_up = 0;
        checks++;
        if ({a_pac_x, a_pac_y, a_score, a_win} !== {2'd1, 2'd2, 8'd3, 1'b1}) begin
            errors++;
            $display("FAIL win_freeze actual x=%0d y=%0d score=%0d win=%b required x=1 y=2 score=3 win=1",
                     a_pac_x, a_pac_y, a_score, a_win);
        end
        checks++;
        if (b_vec !== exp_vec(1)) begin
            errors++;
            $display("FAIL win_model_b actual=%h required=%h", b_vec, exp_vec(1));
        end
    endtask

    task automatic test_ghost();
        clear_inputs();
        apply_reset();
        ghost_valid = 1; ghost_x = 2; ghost_y = 1;
        m_right = 1; step(); m_right = 0;
        checks++;
        if ({a_pac_x, a_pac_y, a_loose} !== {2'd2, 2'd1, 1'b0}) begin
            errors++;
            $display("FAIL ghost_arrive actual x=%0d y=%0d loose=%b required x=2 y=1 loose=0",
                     a_pac_x, a_pac_y, a_loose);
        end
        step();
        checks++;
        if ({a_loose, a_win, a_score} !== {1'b1, 1'b0, 8'd1}) begin
            errors++;
            $display("FAIL ghost_loose actual loose=%b win=%b score=%0d required loose=1 win=0 score=1",
                     a_loose, a_win, a_score);
        end
        m_down = 1; step(); m_down = 0;
        checks++;
        if ({a_pac_x, a_pac_y, a_loose, a_score} !== {2'd2, 2'd1, 1'b1, 8'd1}) begin
            errors++;
            $display("FAIL ghost_freeze actual x=%0d y=%0d loose=%b score=%0d required x=2 y=1 loose=1 score=1",
                     a_pac_x, a_pac_y, a_loose, a_score);
        end
        ghost_x = 1; ghost_y = 2;
        apply_reset();
        run_to_win();
        checks++;
        if ({a_pac_x, a_pac_y, a_score, a_loose} !== {2'd1, 2'd2, 8'd2, 1'b0}) begin
            errors++;
            $display("FAIL ghost_last_path actual score=%0d loose=%b required score=2 loose=0",
                     a_score, a_loose);
        end
        step();
        checks++;
        if ({a_score, a_win, a_loose} !== {8'd3, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL ghost_last_pellet actual score=%0d win=%b loose=%b required score=3 win=0 loose=1",
                     a_score, a_win, a_loose);
        end
        ghost_valid = 0;
    endtask

    task automatic test_tick_div();
        clear_inputs();
        m_down = 1;
        apply_reset();
        for (int k = 1; k <= 8; k++) begin
            step();
            checks++;
            if ({b_pac_x, b_pac_y} !== {2'd1, (k >= 4) ? 2'd2 : 2'd1}) begin
                errors++;
                $display("FAIL tick_div edge=%0d actual x=%0d y=%0d required x=1 y=%0d",
                         k, b_pac_x, b_pac_y, (k >= 4) ? 2 : 1);
            end
        end
        m_down = 0;
    endtask

    task automatic test_restart();
        clear_inputs();
        apply_reset();
        run_to_win();
        step();
        checks++;
        if (a_win !== 1'b1) begin
            errors++;
            $display("FAIL restart_prewin actual=%b required=1", a_win);
        end
        e_start = 1; step(); e_start = 0;
        checks++;
        if ({a_pac_x, a_pac_y, a_score, a_win, a_loose} !== {2'd1, 2'd1, 8'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL restart_clear actual x=%0d y=%0d score=%0d win=%b required x=1 y=1 score=0 win=0",
                     a_pac_x, a_pac_y, a_score, a_win);
        end
        m_right = 1; step(); m_right = 0;
        step();
        checks++;
        if ({a_pac_x, a_pac_y, a_score} !== {2'd2, 2'd1, 8'd1}) begin
            errors++;
            $display("FAIL restart_move actual x=%0d y=%0d score=%0d required x=2 y=1 score=1",
                     a_pac_x, a_pac_y, a_score);
        end
        checks++;
        if (b_vec !== exp_vec(1)) begin
            errors++;
            $display("FAIL restart_model_b actual=%h required=%h", b_vec, exp_vec(1));
        end
    endtask

    task automatic test_random();
        logic [3:0] dirs;
        clear_inputs();
        apply_reset();
        for (int i = 0; i < 600; i++) begin
            dirs = 4'($urandom_range(0, 15));
            {m_up, m_down, m_right, m_left} = dirs;
            m_hold = (dirs == 4'd0);
            e_start = ($urandom_range(0, 39) == 0);
            ghost_valid = ($urandom_range(0, 7) == 0);
            ghost_x = 2'($urandom_range(0, 3));
            ghost_y = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 99) == 0) begin
                reset = 1'b1;
                model_reset(0);
                model_reset(1);
                #1;
                checks++;
                if ({a_vec, b_vec} !== {exp_vec(0), exp_vec(1)}) begin
                    errors++;
                    $display("FAIL async_reset iter=%0d actual=%h/%h required=%h/%h",
                             i, a_vec, b_vec, exp_vec(0), exp_vec(1));
                end
                reset = 1'b0;
            end
            step();
            checks++;
            if (a_vec !== exp_vec(0)) begin
                errors++;
                $display("FAIL random_a iter=%0d actual=%h required=%h", i, a_vec, exp_vec(0));
            end
            checks++;
            if (b_vec !== exp_vec(1)) begin
                errors++;
                $display("FAIL random_b iter=%0d actual=%h required=%h", i, b_vec, exp_vec(1));
            end
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_right_wall();
        test_win();
        test_ghost();
        test_tick_div();
        test_restart();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
